accum_shift_sequencer: RTL and testbench
========================================

Name: accum_shift_sequencer

Overview:
- Initiator side of the accumulator shift-register command interface.
- Accepts one accumulator op (CLR/SET/LOAD/shift/rotate plus a count) from the control unit over a valid/ready handshake.
- Drives the accumulator's ctrl, num_shift, Ls, Rs, clr and set inputs as a sequence of single-bit steps, one per clk.
- Reads the accumulator output back to build the fill bits for arithmetic and rotate ops, and reports the last bit shifted out as carry.

Parameters:
- N, 8, accumulator width; acc_q width. Count width is fixed at 3 bits.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- op_valid  in  1  op request.
- op_ready  out  1  high only in IDLE; an op is accepted on a posedge with op_valid && op_ready.
- op_code  in  3  000 CLR, 001 SET, 010 LOAD, 011 LSL, 100 LSR, 101 ASR, 110 ROL, 111 ROR.
- op_count  in  3  shift steps, 0..7; ignored for CLR/SET/LOAD.
- acc_q  in  N  current accumulator output (registered in the accumulator).
- acc_ctrl  out  2  00 hold, 01 parallel load, 10 left shift, 11 right shift.
- acc_num_shift  out  3  constant 3'd1; every shift is issued as single steps.
- acc_ls  out  1  left-shift fill bit.
- acc_rs  out  1  right-shift fill bit.
- acc_clr_n  out  1  accumulator synchronous clear, active low.
- acc_set_n  out  1  accumulator synchronous set, active low.
- busy  out  1  high in EXEC/SHIFT/DONE.
- done  out  1  one-cycle pulse at op completion.
- carry_out  out  1  last bit shifted out; holds between ops.

Behaviour:
- Reset (async, immediate):
  - State IDLE; acc_ctrl=00; acc_clr_n=acc_set_n=1; acc_ls=acc_rs=0.
  - done=0, busy=0, carry_out=0, remaining count=0.
  - Accumulator contents are not touched by this reset.
- Accept: op_code and op_count are captured into registers. op_* inputs are ignored outside IDLE.
- States:
  - IDLE: idle outputs, op_ready=1.
    - CLR, SET or LOAD accepted -> EXEC.
    - Shift/rotate accepted with count>0 -> SHIFT, rem=count.
    - Shift/rotate accepted with count=0 -> DONE; no accumulator command is issued.
  - EXEC (1 cycle), then -> DONE:
    - CLR: acc_clr_n=0.
    - SET: acc_set_n=0.
    - LOAD: acc_ctrl=01.
  - SHIFT: drives one step per cycle; on each posedge rem decrements and carry_out updates.
    - LSL: ctrl=10, ls=0; carry<=acc_q[N-1].
    - LSR: ctrl=11, rs=0; carry<=acc_q[0].
    - ASR: ctrl=11, rs=acc_q[N-1]; carry<=acc_q[0].
    - ROL: ctrl=10, ls=acc_q[N-1]; carry<=acc_q[N-1].
    - ROR: ctrl=11, rs=acc_q[0]; carry<=acc_q[0].
    - rem==1 at the edge -> DONE.
  - DONE (1 cycle): done=1, busy=1, op_ready=0, acc_ctrl=00 -> IDLE.
- Unused fill bit is 0. Fill bits are combinational from acc_q, which reflects the previous step.
- Latency, accept edge to done cycle:
  - shift by k>0: k+1 cycles.
  - CLR/SET/LOAD: 2 cycles.
  - count=0: 1 cycle.
  - Next op can be accepted on the edge that ends DONE+1, i.e. in IDLE.
- carry_out changes only during SHIFT steps. CLR/SET/LOAD and count=0 leave it unchanged.
- Never drive clr_n and set_n low together. Never assert clr_n/set_n low in the same cycle as ctrl≠00.
- rst mid-op: the sequence aborts immediately. The accumulator keeps whatever the steps already completed have produced.

Decomposition:
- Shared package (acc_pkg):
  - Opcode constants.
  - ACC_HOLD/LOAD/SHL/SHR ctrl codes.
  - State encoding: IDLE, EXEC, SHIFT, DONE.
- Single module. Fill/carry selection is a small case block inside it; no sub-module is warranted.

Test Plan:
- LOAD 0x96 (Reg_in=0x96), then ASR count 3: acc_q steps 0x96->0xCB->0xE5->0xF2; carry_out=1; done 4 cycles after the ASR accept.
- acc=0x96, ROL count 2: acc_q 0x2D then 0x5A; carry_out=0; acc_ls follows acc_q[7] each step (1, then 0).
- acc=0x01, ROR count 1: acc_q=0x80, carry_out=1. Then LSL count 7 from 0x81: final 0x80, carry_out=0.
- LSR count 0: acc_ctrl stays 00 throughout; done pulses the cycle after accept; carry_out unchanged; op_ready low for exactly 1 cycle.
- CLR then SET: acc_clr_n low exactly one cycle (acc->0x00), then acc_set_n low one cycle (acc->0xFF); never both low together.
- rst asserted after 2 steps of ASR 3 from 0x96: outputs idle immediately, acc_q holds 0xE5, no done pulse, carry_out=0. op_valid held high during busy is ignored; accepted only once back in IDLE.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator shift sequencer:
// opcodes, accumulator ctrl codes and sequencer states.
package acc_pkg;

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_SET  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_LSL  = 3'b011;
    localparam logic [2:0] OP_LSR  = 3'b100;
    localparam logic [2:0] OP_ASR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_ROR  = 3'b111;

    localparam logic [1:0] ACC_HOLD = 2'b00;
    localparam logic [1:0] ACC_LOAD = 2'b01;
    localparam logic [1:0] ACC_SHL  = 2'b10;
    localparam logic [1:0] ACC_SHR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } seq_state_t;

endpackage

// File: rtl/accum_shift_sequencer.sv
// Breaks one accumulator op into single-bit steps, one per clk,
// building fill bits from acc_q and tracking the shifted-out carry.
module accum_shift_sequencer
    import acc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   op_code,
    input  logic [2:0]   op_count,
    input  logic [N-1:0] acc_q,
    output logic [1:0]   acc_ctrl,
    output logic [2:0]   acc_num_shift,
    output logic         acc_ls,
    output logic         acc_rs,
    output logic         acc_clr_n,
    output logic         acc_set_n,
    output logic         busy,
    output logic         done,
    output logic         carry_out
);

    seq_state_t state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] rem_q, rem_d;
    logic       carry_q, carry_d;

    logic msb;
    logic lsb;
    logic acc_mid_unused;

    assign msb = acc_q[N-1];
    assign lsb = acc_q[0];
    assign acc_mid_unused = ^acc_q[N-2:1];

    assign acc_num_shift = 3'd1;
    assign op_ready = (state_q == IDLE);
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign carry_out = carry_q;

    // State, captured op, remaining steps and carry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q <= OP_CLR;
            rem_q <= 3'd0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            rem_q <= rem_d;
            carry_q <= carry_d;
        end
    end

    // Next-state logic and accumulator command outputs
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        rem_d = rem_q;
        carry_d = carry_q;
        acc_ctrl = ACC_HOLD;
        acc_ls = 1'b0;
        acc_rs = 1'b0;
        acc_clr_n = 1'b1;
        acc_set_n = 1'b1;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d = op_code;
                    if (op_code == OP_CLR || op_code == OP_SET ||
                        op_code == OP_LOAD) begin
                        state_d = EXEC;
                    end else if (op_count != 3'd0) begin
                        rem_d = op_count;
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            EXEC: begin
                case (op_q)
                    OP_CLR:  acc_clr_n = 1'b0;
                    OP_SET:  acc_set_n = 1'b0;
                    OP_LOAD: acc_ctrl = ACC_LOAD;
                    default: ;
                endcase
                state_d = DONE;
            end
            SHIFT: begin
                rem_d = rem_q - 3'd1;
                case (op_q)
                    OP_LSL: begin
                        acc_ctrl = ACC_SHL;
                        carry_d = msb;
                    end
                    OP_LSR: begin
                        acc_ctrl = ACC_SHR;
                        carry_d = lsb;
                    end
                    OP_ASR: begin
                        acc_ctrl = ACC_SHR;
                        acc_rs = msb;
                        carry_d = lsb;
                    end
                    OP_ROL: begin
                        acc_ctrl = ACC_SHL;
                        acc_ls = msb;
                        carry_d = msb;
                    end
                    OP_ROR: begin
                        acc_ctrl = ACC_SHR;
                        acc_rs = lsb;
                        carry_d = lsb;
                    end
                    default: ;
                endcase
                if (rem_q == 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_accum_shift_sequencer.sv
// Directed bench for accum_shift_sequencer with a behavioural
// 8-bit accumulator model closing the acc_q loop.
module tb_accum_shift_sequencer;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic [2:0]   op_code;
    logic [2:0]   op_count;
    logic [N-1:0] acc_q;
    logic [1:0]   acc_ctrl;
    logic [2:0]   acc_num_shift;
    logic         acc_ls;
    logic         acc_rs;
    logic         acc_clr_n;
    logic         acc_set_n;
    logic         busy;
    logic         done;
    logic         carry_out;

    logic [N-1:0] reg_in;
    int vectors;
    int miscompares;
    int clr_cnt;
    int set_cnt;
    int illegal;
    int lat;

    accum_shift_sequencer #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op_code(op_code),
        .op_count(op_count),
        .acc_q(acc_q),
        .acc_ctrl(acc_ctrl),
        .acc_num_shift(acc_num_shift),
        .acc_ls(acc_ls),
        .acc_rs(acc_rs),
        .acc_clr_n(acc_clr_n),
        .acc_set_n(acc_set_n),
        .busy(busy),
        .done(done),
        .carry_out(carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator model; not affected by the sequencer reset
    always_ff @(posedge clk) begin
        if (!acc_clr_n) acc_q <= '0;
        else if (!acc_set_n) acc_q <= '1;
        else begin
            case (acc_ctrl)
                2'b01: acc_q <= reg_in;
                2'b10: acc_q <= {acc_q[N-2:0], acc_ls};
                2'b11: acc_q <= {acc_rs, acc_q[N-1:1]};
                default: ;
            endcase
        end
    end

    // Strobe counters and illegal-combination monitor
    always @(negedge clk) begin
        if (!acc_clr_n) clr_cnt <= clr_cnt + 1;
        if (!acc_set_n) set_cnt <= set_cnt + 1;
        if ((!acc_clr_n && !acc_set_n) ||
            ((!acc_clr_n || !acc_set_n) && acc_ctrl != 2'b00))
            illegal <= illegal + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op from a negedge; returns the done-cycle index
    // (cycle 1 = the cycle right after the accept edge)
    task automatic do_op(input logic [2:0] code, input logic [2:0] cnt,
                         input logic [N-1:0] data, output int n);
        reg_in = data;
        op_code = code;
        op_count = cnt;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] code, input logic [2:0] cnt);
        op_code = code;
        op_count = cnt;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clr_cnt = 0;
        set_cnt = 0;
        illegal = 0;
        rst = 1'b1;
        op_valid = 1'b0;
        op_code = 3'b000;
        op_count = 3'd0;
        reg_in = 8'h00;

        @(negedge clk);
        chk("rst_ready", op_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_ctrl", acc_ctrl, 0);
        chk("rst_clrset", {acc_clr_n, acc_set_n}, 2'b11);
        chk("rst_fill", {acc_ls, acc_rs}, 2'b00);
        chk("num_shift", acc_num_shift, 1);
        rst = 1'b0;
        @(negedge clk);

        do_op(3'b010, 3'd0, 8'h96, lat);
        chk("load_lat", lat, 2);
        chk("load_acc", acc_q, 8'h96);

        issue(3'b101, 3'd3);
        chk("asr_c1_ctrl", acc_ctrl, 2'b11);
        chk("asr_c1_rs", acc_rs, 1);
        @(negedge clk);
        chk("asr_c2_acc", acc_q, 8'hCB);
        @(negedge clk);
        chk("asr_c3_acc", acc_q, 8'hE5);
        @(negedge clk);
        chk("asr_c4_done", done, 1);
        chk("asr_acc", acc_q, 8'hF2);
        chk("asr_carry", carry_out, 1);
        @(negedge clk);

        do_op(3'b010, 3'd0, 8'h96, lat);
        issue(3'b110, 3'd2);
        chk("rol_s1_ctrl", acc_ctrl, 2'b10);
        chk("rol_s1_ls", acc_ls, 1);
        @(negedge clk);
        chk("rol_s2_acc", acc_q, 8'h2D);
        chk("rol_s2_ls", acc_ls, 0);
        @(negedge clk);
        chk("rol_done", done, 1);
        chk("rol_acc", acc_q, 8'h5A);
        chk("rol_carry", carry_out, 0);
        @(negedge clk);

        do_op(3'b010, 3'd0, 8'h01, lat);
        do_op(3'b111, 3'd1, 8'h00, lat);
        chk("ror_lat", lat, 2);
        chk("ror_acc", acc_q, 8'h80);
        chk("ror_carry", carry_out, 1);

        issue(3'b100, 3'd0);
        chk("lsr0_done", done, 1);
        chk("lsr0_ready", op_ready, 0);
        chk("lsr0_ctrl", acc_ctrl, 0);
        @(negedge clk);
        chk("lsr0_ready2", op_ready, 1);
        chk("lsr0_done2", done, 0);
        chk("lsr0_carry", carry_out, 1);
        chk("lsr0_acc", acc_q, 8'h80);

        do_op(3'b010, 3'd0, 8'h81, lat);
        do_op(3'b011, 3'd7, 8'h00, lat);
        chk("lsl7_lat", lat, 8);
        chk("lsl7_acc", acc_q, 8'h80);
        chk("lsl7_carry", carry_out, 0);

        clr_cnt = 0;
        set_cnt = 0;
        do_op(3'b000, 3'd0, 8'h00, lat);
        chk("clr_lat", lat, 2);
        chk("clr_acc", acc_q, 8'h00);
        chk("clr_cnt", clr_cnt, 1);
        do_op(3'b001, 3'd0, 8'h00, lat);
        chk("set_acc", acc_q, 8'hFF);
        chk("set_cnt", set_cnt, 1);
        chk("clrset_carry", carry_out, 0);

        do_op(3'b010, 3'd0, 8'h96, lat);
        issue(3'b101, 3'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ctrl", acc_ctrl, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_carry", carry_out, 0);
        chk("abort_rs", acc_rs, 0);
        @(negedge clk);
        chk("abort_acc", acc_q, 8'hE5);
        chk("abort_done2", done, 0);
        rst = 1'b0;

        op_code = 3'b100;
        op_count = 3'd1;
        op_valid = 1'b1;
        @(negedge clk);
        chk("hold_c1_busy", busy, 1);
        op_code = 3'b010;
        @(negedge clk);
        chk("hold_c2_done", done, 1);
        chk("hold_c2_acc", acc_q, 8'h72);
        chk("hold_c2_carry", carry_out, 1);
        op_code = 3'b100;
        @(negedge clk);
        chk("hold_c3_idle", busy, 0);
        chk("hold_c3_acc", acc_q, 8'h72);
        @(negedge clk);
        chk("hold_c4_busy", busy, 1);
        op_valid = 1'b0;
        @(negedge clk);
        chk("hold_c5_done", done, 1);
        chk("hold_acc", acc_q, 8'h39);
        chk("hold_carry", carry_out, 0);
        @(negedge clk);
        @(negedge clk);
        chk("no_illegal", illegal, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
